branch_res_station: RTL and testbench

// - Multi-entry, in-order branch reservation station plus resolver.
// - Next generation of the single-slot branch unit; sits between issue logic and branch predictor.
// - Buffers up to NUM_ENTRIES issued conditional branches and snoops the CDB for missing operands.
// - Resolves branches strictly in program order (head first) and reports prediction correctness.

---
 rtl/branch_res_station.sv | 193 +++++++++++++++++++
 tb/tb_branch_res_station.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_res_station.sv
// rtl/branch_res_station.sv - in-order branch reservation station with CDB snoop and resolver
// Optional target calculation (pc/imm storage, redirect_pc_o) under `define BR_TARGET_CALC_EN.
package branch_rs_pkg;
  typedef logic [31:0] word32_t;
  typedef logic [3:0]  rs_tag_t;

  localparam rs_tag_t NO_VAL = 4'd0;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5
  } branch_op_t;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;
endpackage

module branch_res_station
  import branch_rs_pkg::*;
#(
  parameter  int NUM_ENTRIES = 4,
  localparam int PTR_W       = $clog2(NUM_ENTRIES),
  localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  cdb_t       cdb_i,
  input  logic       flush_i,
  input  logic       write_i,
  input  branch_op_t branch_op_type_i,
  input  rs_tag_t    tag1_i,
  input  rs_tag_t    tag2_i,
  input  word32_t    val1_i,
  input  word32_t    val2_i,
  input  logic       br_taken_i,
`ifdef BR_TARGET_CALC_EN
  input  word32_t    pc_i,
  input  word32_t    imm_i,
  output word32_t    redirect_pc_o,
`endif
  output logic       full_o,
  output logic       empty_o,
  output logic       resolve_valid_o,
  output logic       actual_taken_o,
  output logic       corr_pred_o
);

  typedef struct packed {
    logic       valid;
    branch_op_t op;
    rs_tag_t    tag1;
    rs_tag_t    tag2;
    word32_t    val1;
    word32_t    val2;
    logic       pred;
`ifdef BR_TARGET_CALC_EN
    word32_t    pc;
    word32_t    imm;
`endif
  } entry_t;

  entry_t             slots [NUM_ENTRIES];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  entry_t             head_e;
  entry_t             new_e;
  logic               head_ready;
  logic               head_taken;
  logic               do_write;

  function automatic logic eval_cond(input branch_op_t op, input word32_t a, input word32_t b);
    logic r;
    r = 1'b0;
    case (op)
      BEQ:     r = (a == b);
      BNE:     r = (a != b);
      BLT:     r = ($signed(a) <  $signed(b));
      BGE:     r = ($signed(a) >= $signed(b));
      BLTU:    r = (a <  b);
      BGEU:    r = (a >= b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign full_o  = (count == CNT_W'(NUM_ENTRIES));
  assign empty_o = (count == '0);

  // Only the oldest entry may resolve, so readiness is checked at head alone.
  always_comb begin
    head_e     = slots[head];
    head_ready = head_e.valid && (head_e.tag1 == NO_VAL) && (head_e.tag2 == NO_VAL);
    head_taken = eval_cond(head_e.op, head_e.val1, head_e.val2);
    do_write   = write_i && !full_o;
  end

  // New entry, with operands forwarded from a CDB broadcast in the same cycle.
  always_comb begin
    new_e       = '0;
    new_e.valid = 1'b1;
    new_e.op    = branch_op_type_i;
    new_e.tag1  = tag1_i;
    new_e.tag2  = tag2_i;
    new_e.val1  = val1_i;
    new_e.val2  = val2_i;
    new_e.pred  = br_taken_i;
`ifdef BR_TARGET_CALC_EN
    new_e.pc    = pc_i;
    new_e.imm   = imm_i;
`endif
    if (tag1_i != NO_VAL && cdb_i.tag == tag1_i) begin
      new_e.tag1 = NO_VAL;
      new_e.val1 = cdb_i.val;
    end
    if (tag2_i != NO_VAL && cdb_i.tag == tag2_i) begin
      new_e.tag2 = NO_VAL;
      new_e.val2 = cdb_i.val;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      resolve_valid_o <= 1'b0;
      actual_taken_o  <= 1'b0;
      corr_pred_o     <= 1'b0;
`ifdef BR_TARGET_CALC_EN
      redirect_pc_o   <= '0;
`endif
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        slots[i] <= '0;
      end
    end else if (flush_i) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      resolve_valid_o <= 1'b0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        slots[i].valid <= 1'b0;
      end
    end else begin
      resolve_valid_o <= head_ready;
      if (head_ready) begin
        actual_taken_o <= head_taken;
        corr_pred_o    <= (head_taken == head_e.pred);
`ifdef BR_TARGET_CALC_EN
        redirect_pc_o  <= head_e.pc + (head_taken ? head_e.imm : 32'd4);
`endif
        head           <= head + PTR_W'(1);
      end

      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (slots[i].valid && cdb_i.tag != NO_VAL) begin
          if (slots[i].tag1 == cdb_i.tag) begin
            slots[i].tag1 <= NO_VAL;
            slots[i].val1 <= cdb_i.val;
          end
          if (slots[i].tag2 == cdb_i.tag) begin
            slots[i].tag2 <= NO_VAL;
            slots[i].val2 <= cdb_i.val;
          end
        end
      end

      if (head_ready) begin
        slots[head].valid <= 1'b0;
      end

      // Tail slot is never valid when not full, so this cannot collide with snoop or free.
      if (do_write) begin
        slots[tail] <= new_e;
        tail        <= tail + PTR_W'(1);
      end

      case ({do_write, head_ready})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_res_station.sv
// tb/tb_branch_res_station.sv - randomized and directed self-checking bench for branch_res_station
module tb_branch_res_station;
  import branch_rs_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_i;
  cdb_t       cdb;
  logic       flush, write, pred;
  branch_op_t op;
  rs_tag_t    t1, t2;
  word32_t    v1, v2, pc, imm;
  logic       full, empty, rv, at, cp;
  word32_t    rpc;

  always #5 clk = ~clk;

  branch_res_station #(.NUM_ENTRIES(N)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .cdb_i            (cdb),
    .flush_i          (flush),
    .write_i          (write),
    .branch_op_type_i (op),
    .tag1_i           (t1),
    .tag2_i           (t2),
    .val1_i           (v1),
    .val2_i           (v2),
    .br_taken_i       (pred),
`ifdef BR_TARGET_CALC_EN
    .pc_i             (pc),
    .imm_i            (imm),
    .redirect_pc_o    (rpc),
`endif
    .full_o           (full),
    .empty_o          (empty),
    .resolve_valid_o  (rv),
    .actual_taken_o   (at),
    .corr_pred_o      (cp)
  );

`ifndef BR_TARGET_CALC_EN
  assign rpc = '0;
`endif

  typedef struct {
    int      op;
    rs_tag_t t1, t2;
    word32_t v1, v2;
    logic    pred;
    word32_t pc, imm;
  } ment_t;

  ment_t   mq[$];
  logic    e_rv = 1'b0, e_at = 1'b0, e_cp = 1'b0;
  word32_t e_rpc = '0;
  int      n_chk = 0, n_fail = 0;
  bit      cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_taken(input int o, input word32_t a, input word32_t b);
    case (o)
      0: return a == b;
      1: return a != b;
      2: return $signed(a) < $signed(b);
      3: return $signed(a) >= $signed(b);
      4: return a < b;
      5: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Applies the station rules to the queue model for the edge just taken.
  task automatic model_step();
    bit    pre_full;
    ment_t e;
    if (reset_i) begin
      mq.delete();
      e_rv = 0; e_at = 0; e_cp = 0; e_rpc = '0;
      return;
    end
    if (flush) begin
      mq.delete();
      e_rv = 0;
      return;
    end
    pre_full = (mq.size() == N);
    e_rv = 0;
    if (mq.size() > 0 && mq[0].t1 == NO_VAL && mq[0].t2 == NO_VAL) begin
      e_rv  = 1;
      e_at  = model_taken(mq[0].op, mq[0].v1, mq[0].v2);
      e_cp  = (e_at == mq[0].pred);
      e_rpc = mq[0].pc + (e_at ? mq[0].imm : 32'd4);
      void'(mq.pop_front());
    end
    if (cdb.tag != NO_VAL) begin
      foreach (mq[i]) begin
        if (mq[i].t1 == cdb.tag) begin mq[i].t1 = NO_VAL; mq[i].v1 = cdb.val; end
        if (mq[i].t2 == cdb.tag) begin mq[i].t2 = NO_VAL; mq[i].v2 = cdb.val; end
      end
    end
    if (write && !pre_full) begin
      e.op = int'(op); e.t1 = t1; e.t2 = t2; e.v1 = v1; e.v2 = v2;
      e.pred = pred; e.pc = pc; e.imm = imm;
      if (t1 != NO_VAL && cdb.tag == t1) begin e.t1 = NO_VAL; e.v1 = cdb.val; end
      if (t2 != NO_VAL && cdb.tag == t2) begin e.t2 = NO_VAL; e.v2 = cdb.val; end
      mq.push_back(e);
    end
  endtask

  task automatic idle_inputs();
    write = 0; flush = 0; cdb = '0;
    op = BEQ; t1 = NO_VAL; t2 = NO_VAL; v1 = '0; v2 = '0; pred = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    idle_inputs();
  endtask

  task automatic set_wr(input branch_op_t o, input rs_tag_t at1, input word32_t av1,
                        input rs_tag_t at2, input word32_t av2, input logic p);
    write = 1; op = o; t1 = at1; v1 = av1; t2 = at2; v2 = av2; pred = p;
  endtask

  function automatic word32_t rand_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return word32_t'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("resolve_valid", 32'(rv), 32'(e_rv));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == N));
      if (e_rv) begin
        chk("actual_taken", 32'(at), 32'(e_at));
        chk("corr_pred", 32'(cp), 32'(e_cp));
`ifdef BR_TARGET_CALC_EN
        chk("redirect_pc", rpc, e_rpc);
`endif
      end
    end
  end

  initial begin
    reset_i = 1;
    idle_inputs();
    pc = 32'h100; imm = 32'h20;
    cyc(); cyc();
    chk("reset_rv", 32'(rv), 0);
    chk("reset_empty", 32'(empty), 1);
    chk("reset_full", 32'(full), 0);
    chk("reset_at", 32'(at), 0);
    chk("reset_cp", 32'(cp), 0);
    chk("reset_rpc", rpc, 0);
    reset_i = 0;
    cmp_en = 1;

    // Ready BLT -1 < 1, predicted taken.
    set_wr(BLT, NO_VAL, 32'hFFFF_FFFF, NO_VAL, 32'd1, 1);
    cyc();
    chk("t1_no_early_rv", 32'(rv), 0);
    cyc();
    chk("t1_rv", 32'(rv), 1);
    chk("t1_at", 32'(at), 1);
    chk("t1_cp", 32'(cp), 1);
`ifdef BR_TARGET_CALC_EN
    chk("t1_rpc", rpc, 32'h120);
`endif
    cyc();
    chk("t1_single_pulse", 32'(rv), 0);

    // BNE waiting on tag 3, CDB two cycles later.
    set_wr(BNE, 4'd3, 32'd0, NO_VAL, 32'd5, 1);
    cyc(); cyc();
    cdb.tag = 4'd3; cdb.val = 32'd5;
    cyc();
    chk("t2_capture_not_resolvable", 32'(rv), 0);
    cyc();
    chk("t2_rv", 32'(rv), 1);
    chk("t2_at", 32'(at), 0);
    chk("t2_cp", 32'(cp), 0);
`ifdef BR_TARGET_CALC_EN
    chk("t2_rpc", rpc, 32'h104);
`endif

    // Write-time forwarding.
    set_wr(BEQ, 4'd2, 32'd0, NO_VAL, 32'd7, 0);
    cdb.tag = 4'd2; cdb.val = 32'd7;
    cyc(); cyc();
    chk("t3_rv", 32'(rv), 1);
    chk("t3_at", 32'(at), 1);
    chk("t3_cp", 32'(cp), 0);

    // Unknown opcode never takes, even with equal operands.
    set_wr(branch_op_t'(3'd7), NO_VAL, 32'd5, NO_VAL, 32'd5, 0);
    cyc(); cyc();
    chk("t3b_rv", 32'(rv), 1);
    chk("t3b_at", 32'(at), 0);
    chk("t3b_cp", 32'(cp), 1);

    // Fill with head blocked on tag 4; a fifth write is dropped.
    set_wr(BEQ, 4'd4, 32'd0, NO_VAL, 32'd9, 1); cyc();
    set_wr(BNE, NO_VAL, 32'd3, NO_VAL, 32'd3, 1); cyc();
    set_wr(BLTU, NO_VAL, 32'd1, NO_VAL, 32'd2, 1); cyc();
    set_wr(BGE, NO_VAL, 32'hFFFF_FFFB, NO_VAL, 32'd2, 1); cyc();
    chk("t4_full", 32'(full), 1);
    cyc();
    chk("t4_blocked_a", 32'(rv), 0);
    cyc();
    chk("t4_blocked_b", 32'(rv), 0);
    set_wr(BEQ, NO_VAL, 32'd0, NO_VAL, 32'd0, 1);
    cdb.tag = 4'd4; cdb.val = 32'd9;
    cyc();
    chk("t4_capture_cycle", 32'(rv), 0);
    chk("t4_still_full", 32'(full), 1);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t5_pulse_rv", 32'(rv), 1);
      chk("t5_pulse_order", 32'(at), 32'((k % 2) == 0));
    end
    cyc();
    chk("t5_fifth_dropped", 32'(rv), 0);
    chk("t5_empty", 32'(empty), 1);

    // Flush with three waiting entries and a simultaneous CDB and write.
    for (int k = 0; k < 3; k++) begin
      set_wr(BEQ, 4'd1, 32'd0, NO_VAL, 32'd0, 1);
      cyc();
    end
    flush = 1; cdb.tag = 4'd1; cdb.val = 32'd0;
    set_wr(BEQ, NO_VAL, 32'd0, NO_VAL, 32'd0, 1);
    cyc();
    chk("t6_empty", 32'(empty), 1);
    chk("t6_rv", 32'(rv), 0);
    cyc();
    chk("t6_no_late_rv", 32'(rv), 0);
    chk("t6_still_empty", 32'(empty), 1);

    // Asynchronous reset while a resolve pulse is showing.
    set_wr(BEQ, NO_VAL, 32'd4, NO_VAL, 32'd4, 1); cyc();
    set_wr(BEQ, NO_VAL, 32'd4, NO_VAL, 32'd4, 1); cyc();
    chk("t7_pre_rv", 32'(rv), 1);
    reset_i = 1;
    model_step();
    #2;
    chk("t7_async_rv", 32'(rv), 0);
    chk("t7_async_at", 32'(at), 0);
    chk("t7_async_cp", 32'(cp), 0);
    chk("t7_async_empty", 32'(empty), 1);
    chk("t7_async_full", 32'(full), 0);
    cyc();
    reset_i = 0;

    // Randomized traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 1) == 1) begin
        set_wr(branch_op_t'(3'($urandom_range(0, 7))),
               ($urandom_range(0, 2) == 0) ? rs_tag_t'($urandom_range(1, 4)) : NO_VAL, rand_val(),
               ($urandom_range(0, 2) == 0) ? rs_tag_t'($urandom_range(1, 4)) : NO_VAL, rand_val(),
               1'($urandom_range(0, 1)));
        pc  = word32_t'($urandom);
        imm = word32_t'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        cdb.tag = rs_tag_t'($urandom_range(1, 4));
        cdb.val = rand_val();
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
